// File: rtl/dmem_if.sv
`default_nettype none
// =============================================================================
// Module   : dmem_if
// Brief    : MEM-stage data-memory handshake bundle (request, write data, response).
// Revision : 1.0
// =============================================================================
interface dmem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();
   logic                  W_EN;
   logic                  R_EN;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     data_in;
   logic [DATA_W/8-1:0]   byte_en;
   logic [DATA_W-1:0]     data_out;
   logic                  ready;
   logic                  err;

   modport master (
      output W_EN, R_EN, address, data_in, byte_en,
      input  data_out, ready, err
   );

   modport slave (
      input  W_EN, R_EN, address, data_in, byte_en,
      output data_out, ready, err
   );
endinterface
`default_nettype wire

// File: rtl/dmem_waitstate.sv
`default_nettype none
// =============================================================================
// Module   : dmem_waitstate
// Brief    : Word-addressed data memory with programmable wait states, byte-lane
//            writes, range checking and a one-cycle ready/err completion strobe.
//            Define DMEM_ALIGN_CHECK_EN to fault misaligned addresses.
// Revision : 1.0
// =============================================================================
module dmem_waitstate #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_STATES = 2
) (
   input wire     clk,
   input wire     rst,
   dmem_if.slave  bus
);

   localparam int                c_BYTES     = DATA_W / 8;
   localparam int                c_SHIFT     = $clog2(c_BYTES);
   localparam int                c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] c_DEPTH     = ADDR_W'(DEPTH);
   localparam logic [3:0]        c_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;

   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [c_BYTES-1:0]  r_be;
   logic                r_is_wr;

   logic [DATA_W-1:0]   r_data_out;
   logic                r_ready;
   logic                r_err;

   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_req;
   logic                w_capture;
   logic                w_access;
   logic                w_under;
   logic [ADDR_W-1:0]   w_diff;
   logic [ADDR_W-1:0]   w_index;
   logic [c_IDX_W-1:0]  w_mem_idx;
   logic                w_oor;
   logic                w_misaligned;
   logic                w_fault;
   logic                w_commit_wr;
   logic                w_commit_rd;

   assign w_req = bus.W_EN | bus.R_EN;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state. Requests are only looked at in IDLE, so a master that
   // drops its request mid-access cannot cancel it.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_IDLE: begin
            if (w_req) begin
               if (WAIT_STATES > 0) begin
                  w_state_nxt = c_WAIT;
                  w_cnt_nxt   = c_WAIT_INIT;
               end else begin
                  w_state_nxt = c_DONE;
               end
            end
         end
         c_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = c_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         c_DONE: begin
            w_state_nxt = c_IDLE;
         end
         default: begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: output decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_capture   = 1'b0;
      w_access    = 1'b0;
      w_commit_wr = 1'b0;
      w_commit_rd = 1'b0;
      case (r_state)
         c_IDLE: w_capture = w_req;
         c_DONE: begin
            w_access    = ~rst;
            w_commit_wr = ~rst & r_is_wr & ~w_fault;
            w_commit_rd = ~rst & ~r_is_wr;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Address decode on the latched request. The borrow is checked
   // explicitly so an address below the base never wraps into range.
   // ---------------------------------------------------------------------
   assign w_under   = (r_addr < c_BASE);
   assign w_diff    = r_addr - c_BASE;
   assign w_index   = w_diff >> c_SHIFT;
   assign w_mem_idx = w_index[c_IDX_W-1:0];
   assign w_oor     = w_under | (w_index >= c_DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
   localparam logic [ADDR_W-1:0] c_OFF_MASK = ADDR_W'(c_BYTES - 1);
   assign w_misaligned = |(r_addr & c_OFF_MASK);
`else
   assign w_misaligned = 1'b0;
`endif

   assign w_fault = w_oor | w_misaligned;

   // ---------------------------------------------------------------------
   // Request capture
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_is_wr <= 1'b0;
      end else if (w_capture) begin
         r_addr  <= bus.address;
         r_wdata <= bus.data_in;
         r_be    <= bus.byte_en;
         r_is_wr <= bus.W_EN;
      end
   end

   // ---------------------------------------------------------------------
   // Response registers: ready/err strobe for one cycle, data_out holds
   // until the next completed read.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready    <= 1'b0;
         r_err      <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_ready <= w_access;
         r_err   <= w_access & w_fault;
         if (w_commit_rd) begin
            r_data_out <= w_fault ? '0 : r_mem[w_mem_idx];
         end
      end
   end

   // Storage is deliberately not reset; only the selected byte lanes change.
   always_ff @(posedge clk) begin
      if (w_commit_wr) begin
         for (int b = 0; b < c_BYTES; b++) begin
            if (r_be[b]) begin
               r_mem[w_mem_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.data_out = r_data_out;
   assign bus.ready    = r_ready;
   assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_waitstate.sv
`default_nettype none
// =============================================================================
// Module   : tb_dmem_waitstate
// Brief    : Self-checking bench: directed scenarios plus random accesses against
//            an array model of the memory, on a 2-wait-state and a 0-wait-state DUT.
// Revision : 1.0
// =============================================================================
module tb_dmem_waitstate;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [31:0] model    [2][64];
   logic [31:0] exp_dout [2];

   always #5 clk = ~clk;

   dmem_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
   dmem_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();

   dmem_waitstate #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_STATES(2)
   ) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0)
   );

   dmem_waitstate #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_STATES(0)
   ) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input int which, input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      if (which == 0) begin
         bus0.W_EN = wr; bus0.R_EN = rd; bus0.address = a; bus0.data_in = d; bus0.byte_en = be;
      end else begin
         bus1.W_EN = wr; bus1.R_EN = rd; bus1.address = a; bus1.data_in = d; bus1.byte_en = be;
      end
   endtask

   function automatic logic get_ready(input int which);
      return (which == 0) ? bus0.ready : bus1.ready;
   endfunction

   function automatic logic get_err(input int which);
      return (which == 0) ? bus0.err : bus1.err;
   endfunction

   function automatic logic [31:0] get_dout(input int which);
      return (which == 0) ? bus0.data_out : bus1.data_out;
   endfunction

   // Reference rules: window of 64 words starting at byte 1024, word = 4 bytes.
   function automatic bit is_fault(input logic [31:0] a);
      longint unsigned off;
      if (a < 32'd1024) return 1'b1;
      off = longint'(a) - 1024;
      if (off / 4 >= 64) return 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
      if (a % 4 != 0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   task automatic access(input int which, input bit wr, input bit rd,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit early_drop);
      int          lat;
      int          exp_lat;
      bit          seen;
      bit          fault;
      int          idx;
      logic [31:0] word;
      exp_lat = (which == 0) ? 3 : 1;
      @(negedge clk);
      drive(which, wr, rd, a, d, be);
      @(posedge clk);
      if (early_drop) begin
         #1;
         drive(which, 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
      end
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (get_ready(which)) seen = 1'b1;
         else check("err_without_ready", 32'(get_err(which)), 32'd0);
      end
      check("ready_seen", 32'(seen), 32'd1);
      if (seen) begin
         check("latency", 32'(lat), 32'(exp_lat));
         fault = is_fault(a);
         if (!fault) idx = int'((a - 32'd1024) / 4);
         else idx = 0;
         if (wr) begin
            if (!fault) begin
               word = model[which][idx];
               for (int b = 0; b < 4; b++)
                  if (be[b]) word[8*b +: 8] = d[8*b +: 8];
               model[which][idx] = word;
            end
         end else if (rd) begin
            exp_dout[which] = fault ? 32'd0 : model[which][idx];
         end
         check("err", 32'(get_err(which)), 32'(fault));
         check("data_out", get_dout(which), exp_dout[which]);
      end
      drive(which, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(posedge clk);
      #1;
      check("ready_one_cycle", 32'(get_ready(which)), 32'd0);
   endtask

   initial begin
      bit saw;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 64; i++) model[w][i] = 32'd0;
         exp_dout[w] = 32'd0;
      end
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready0", 32'(bus0.ready), 32'd0);
      check("rst_err0", 32'(bus0.err), 32'd0);
      check("rst_dout0", bus0.data_out, 32'd0);
      check("rst_ready1", 32'(bus1.ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Full-word writes of 1,2,3
      access(0, 1, 0, 32'd1024, 32'd1, 4'hF, 0);
      access(0, 1, 0, 32'd1028, 32'd2, 4'hF, 0);
      access(0, 1, 0, 32'd1032, 32'd3, 4'hF, 0);
      check("t1_dout_unchanged", bus0.data_out, 32'd0);

      // Unaligned reads
      access(0, 0, 1, 32'd1025, 32'd0, 4'h0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
      check("t2_1025", bus0.data_out, 32'd0);
`else
      check("t2_1025", bus0.data_out, 32'd1);
`endif
      access(0, 0, 1, 32'd1030, 32'd0, 4'h0, 0);
      access(0, 0, 1, 32'd1035, 32'd0, 4'h0, 1);
`ifdef DMEM_ALIGN_CHECK_EN
      check("t2_1035", bus0.data_out, 32'd0);
`else
      check("t2_1035", bus0.data_out, 32'd3);
`endif

      // Byte-lane merge
      access(0, 1, 0, 32'd1024, 32'hAABBCCDD, 4'b0101, 0);
      access(0, 0, 1, 32'd1024, 32'd0, 4'h0, 0);
      check("t3_merge", bus0.data_out, 32'h00BB00DD);

      // Range limits
      access(0, 0, 1, 32'd1020, 32'd0, 4'h0, 0);
      access(0, 0, 1, 32'd1280, 32'd0, 4'h0, 0);
      access(0, 1, 0, 32'd1280, 32'hDEADBEEF, 4'hF, 0);
      access(0, 0, 1, 32'd0, 32'd0, 4'h0, 0);
      access(0, 0, 1, 32'd1024, 32'd0, 4'h0, 0);
      check("t4_unaffected", bus0.data_out, 32'h00BB00DD);

      // Reset during WAIT aborts the write
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'd1028, 32'h55, 4'hF);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(posedge clk);
      #1;
      check("t5_rst_dout", bus0.data_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_dout[0] = 32'd0;
      exp_dout[1] = 32'd0;
      saw = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus0.ready) saw = 1'b1;
      end
      check("t5_no_ready", 32'(saw), 32'd0);
      check("t5_err", 32'(bus0.err), 32'd0);
      access(0, 0, 1, 32'd1028, 32'd0, 4'h0, 0);
      check("t5_read_1028", bus0.data_out, 32'd2);

      // Zero wait states
      access(1, 1, 0, 32'd1024, 32'h1234, 4'hF, 0);
      access(1, 0, 1, 32'd1024, 32'd0, 4'h0, 0);
      check("t6_read", bus1.data_out, 32'h1234);
      access(1, 1, 1, 32'd1032, 32'd9, 4'hF, 0);
      check("t6_both_dout", bus1.data_out, 32'h1234);
      access(1, 0, 1, 32'd1032, 32'd0, 4'h0, 0);
      check("t6_both_write", bus1.data_out, 32'd9);

      // Fill every word so the random phase never depends on power-up contents
      for (int i = 0; i < 64; i++)
         access(0, 1, 0, 32'd1024 + 32'(4 * i), $urandom, 4'hF, 0);

      for (int n = 0; n < 150; n++) begin
         int          op;
         int          ac;
         logic [31:0] a;
         op = $urandom_range(0, 9);
         ac = $urandom_range(0, 19);
         if (ac < 15)      a = 32'd1024 + 32'($urandom_range(0, 255));
         else if (ac < 17) a = 32'($urandom_range(0, 1023));
         else if (ac < 19) a = 32'd1280 + 32'($urandom_range(0, 4096));
         else              a = 32'hFFFF_FFFC;
         access($urandom_range(0, 3) == 0 ? 1 : 0,
                op >= 5, (op < 5) || (op == 9), a, $urandom, 4'($urandom),
                $urandom_range(0, 1) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
